display_sw_poller: RTL

Avalon-MM master that periodically reads the switch PIO input register (word address 0, registered read data, one-cycle read latency), debounces the sampled switch field and publishes debounced state plus change events to the display controller over a valid/ready port. It sits between the switch PIO and the display-update logic, replacing software polling of the switch register.

---
 rtl/display_pkg.sv | 16 +
 rtl/display_sw_debounce.sv | 68 ++++++
 rtl/display_sw_poller.sv | 128 ++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the switch poller: poll FSM states, PIO register map, default sizes.
package display_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      READ    = 2'd1,
      CAPTURE = 2'd2
   } poll_state_e;

   localparam logic [1:0] SW_PIO_DATA_ADDR = 2'd0;

   localparam int DEF_POLL_DIV     = 50000;
   localparam int DEF_DATA_W       = 4;
   localparam int DEF_DEBOUNCE_CNT = 8;

endpackage

// File: rtl/display_sw_debounce.sv
// Debounces polled switch samples into a stable state and flags each accepted change.
// DISPLAY_SW_POLLER_DEBOUNCE_EN enables the consecutive-sample filter; otherwise any new value is taken at once.
module display_sw_debounce import display_pkg::*; #(
   parameter int DATA_W       = DEF_DATA_W
`ifdef DISPLAY_SW_POLLER_DEBOUNCE_EN
   ,parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample,
   output logic              change,
   output logic [DATA_W-1:0] diff,
   output logic [DATA_W-1:0] state
);

   logic [DATA_W-1:0] r_state;
   logic              w_change;
   logic [DATA_W-1:0] w_new_state;

`ifdef DISPLAY_SW_POLLER_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);

   logic [DATA_W-1:0] r_cand;
   logic [CNT_W-1:0]  r_stable_cnt;
   logic [DATA_W-1:0] w_cand_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;

   always_comb begin
      // NOTE: every output gets a default first, so no path can leave it unassigned and infer a latch.
      w_cand_nxt = r_cand;
      w_cnt_nxt  = r_stable_cnt;
      if (sample == r_cand) begin
         if (r_stable_cnt != CNT_W'(DEBOUNCE_CNT)) w_cnt_nxt = r_stable_cnt + CNT_W'(1);
      end else begin
         w_cand_nxt = sample;
         w_cnt_nxt  = CNT_W'(1);
      end
   end

   assign w_new_state = w_cand_nxt;
   assign w_change    = sample_valid && (w_cnt_nxt == CNT_W'(DEBOUNCE_CNT)) && (w_cand_nxt != r_state);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cand       <= '0;
         r_stable_cnt <= '0;
      end else if (sample_valid) begin
         r_cand       <= w_cand_nxt;
         r_stable_cnt <= w_cnt_nxt;
      end
   end
`else
   assign w_new_state = sample;
   assign w_change    = sample_valid && (sample != r_state);
`endif

   always_ff @(posedge clk) begin
      if (reset) r_state <= '0;
      else if (w_change) r_state <= w_new_state;
   end

   assign change = w_change;
   assign diff   = w_new_state ^ r_state;
   assign state  = r_state;

endmodule

// File: rtl/display_sw_poller.sv
// Avalon-MM master polling the switch PIO, debouncing it and raising change events for the display.
// Optional DISPLAY_SW_POLLER_DEBOUNCE_EN enables multi-sample debounce (default: accept each new value).
module display_sw_poller import display_pkg::*; #(
   parameter int POLL_DIV     = DEF_POLL_DIV,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT
) (
   input  logic              clk,
   input  logic              reset,
   output logic [1:0]        avm_address,
   output logic              avm_read,
   input  logic              avm_waitrequest,
   input  logic [31:0]       avm_readdata,
   output logic [DATA_W-1:0] sw_state,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [DATA_W-1:0] evt_data,
   output logic [DATA_W-1:0] evt_changed,
   output logic              evt_overflow,
   output logic              poll_overrun
);

   localparam int TICK_W = $clog2(POLL_DIV);

   if (POLL_DIV < 4 || DEBOUNCE_CNT < 1) begin : g_bad_params
      $error("display_sw_poller: POLL_DIV must be >= 4 and DEBOUNCE_CNT >= 1");
   end

   poll_state_e       r_state;
   logic [TICK_W-1:0] r_tick_cnt;
   logic              r_avm_read;
   logic              r_poll_overrun;
   logic              r_evt_valid;
   logic [DATA_W-1:0] r_evt_data;
   logic [DATA_W-1:0] r_evt_changed;
   logic              r_evt_overflow;

   logic              w_tick;
   logic              w_sample_valid;
   logic              w_change;
   logic [DATA_W-1:0] w_diff;
   logic [DATA_W-1:0] w_sw_state;
   logic              w_accept;
   logic              w_unused_rd_hi;

   assign w_tick         = (r_tick_cnt == TICK_W'(POLL_DIV - 1));
   assign w_sample_valid = (r_state == CAPTURE);
   assign w_accept       = r_evt_valid && evt_ready;
   assign w_unused_rd_hi = ^avm_readdata[31:DATA_W];

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (reset || w_tick) r_tick_cnt <= '0;
      else                 r_tick_cnt <= r_tick_cnt + TICK_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= IDLE;
         r_avm_read     <= 1'b0;
         r_poll_overrun <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (w_tick) begin
               r_state    <= READ;
               r_avm_read <= 1'b1;
            end
            READ: if (!avm_waitrequest) begin
               r_state    <= CAPTURE;
               r_avm_read <= 1'b0;
            end
            CAPTURE: r_state <= IDLE;
            default: begin
               r_state    <= IDLE;
               r_avm_read <= 1'b0;
            end
         endcase
         if (w_tick && r_state != IDLE) r_poll_overrun <= 1'b1;
      end
   end

   display_sw_debounce #(
      .DATA_W       (DATA_W)
`ifdef DISPLAY_SW_POLLER_DEBOUNCE_EN
      ,.DEBOUNCE_CNT (DEBOUNCE_CNT)
`endif
   ) u_debounce (
      .clk          (clk),
      .reset        (reset),
      .sample_valid (w_sample_valid),
      .sample       (avm_readdata[DATA_W-1:0]),
      .change       (w_change),
      .diff         (w_diff),
      .state        (w_sw_state)
   );

   // A change arriving in the acceptance cycle starts a fresh event instead of merging.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_evt_valid    <= 1'b0;
         r_evt_data     <= '0;
         r_evt_changed  <= '0;
         r_evt_overflow <= 1'b0;
      end else if (w_change) begin
         r_evt_data <= w_sw_state ^ w_diff;
         if (!r_evt_valid || w_accept) begin
            r_evt_valid   <= 1'b1;
            r_evt_changed <= w_diff;
         end else begin
            r_evt_changed  <= r_evt_changed | w_diff;
            r_evt_overflow <= 1'b1;
         end
      end else if (w_accept) begin
         r_evt_valid   <= 1'b0;
         r_evt_changed <= '0;
      end
   end

   assign avm_address  = SW_PIO_DATA_ADDR;
   assign avm_read     = r_avm_read;
   assign sw_state     = w_sw_state;
   assign evt_valid    = r_evt_valid;
   assign evt_data     = r_evt_data;
   assign evt_changed  = r_evt_changed;
   assign evt_overflow = r_evt_overflow;
   assign poll_overrun = r_poll_overrun;

endmodule
